// File: rtl/eth_latency_tracker_pkg.sv
// ============================================================================
// Module  : eth_latency_pkg
// Brief   : Shared defaults and record types for the ping latency tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_latency_pkg;

  localparam int DEPTH_LOG2_DEF = 4;
  localparam int SEQ_W_DEF      = 16;
  localparam int TIME_W_DEF     = 64;
  localparam int CNT_W_DEF      = 32;

  // Records at the default widths; the tracker builds width-matched copies
  // from its own parameters.
  typedef struct packed {
    logic                  pending;
    logic [SEQ_W_DEF-1:0]  tag;
    logic [TIME_W_DEF-1:0] stamp;
  } slot_rec_t;

  typedef struct packed {
    logic [SEQ_W_DEF-1:0]  seq;
    logic [TIME_W_DEF-1:0] latency;
    logic                  timeout;
  } res_rec_t;

  localparam logic [TIME_W_DEF-1:0] LAT_MIN_INIT = '1;

endpackage

`default_nettype wire

// File: rtl/eth_latency_tracker_if.sv
// ============================================================================
// Module  : eth_latency_tracker_if
// Brief   : Probe tx/rx events and the result handshake of the latency tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface eth_latency_tracker_if #(
  parameter int SEQ_W  = 16,
  parameter int TIME_W = 64
) ();

  logic              tx_valid;
  logic [SEQ_W-1:0]  tx_seq;
  logic              rx_valid;
  logic [SEQ_W-1:0]  rx_seq;
  logic              res_valid;
  logic              res_ready;
  logic [SEQ_W-1:0]  res_seq;
  logic [TIME_W-1:0] res_latency;
  logic              res_timeout;

  modport master (
    output tx_valid, tx_seq, rx_valid, rx_seq, res_ready,
    input  res_valid, res_seq, res_latency, res_timeout
  );

  modport slave (
    input  tx_valid, tx_seq, rx_valid, rx_seq, res_ready,
    output res_valid, res_seq, res_latency, res_timeout
  );

endinterface

`default_nettype wire

// File: rtl/eth_latency_tracker_stats.sv
// ============================================================================
// Module  : eth_latency_stats
// Brief   : Saturating statistics counters, min/max latency, optional sum
//           (lat_sum present when ETH_LATENCY_SUM_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_latency_stats #(
  parameter int TIME_W = 64,
  parameter int CNT_W  = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              stats_clear_i,
  input  wire logic              probe_inc_i,
  input  wire logic              echo_inc_i,
  input  wire logic [TIME_W-1:0] lat_i,
  input  wire logic [1:0]        lost_inc_i,
  input  wire logic              stray_inc_i,
  input  wire logic              drop_inc_i,
  output logic      [CNT_W-1:0]  probe_count_o,
  output logic      [CNT_W-1:0]  echo_count_o,
  output logic      [CNT_W-1:0]  lost_count_o,
  output logic      [CNT_W-1:0]  stray_count_o,
  output logic      [CNT_W-1:0]  drop_count_o,
  output logic      [TIME_W-1:0] lat_min_o,
  output logic      [TIME_W-1:0] lat_max_o
`ifdef ETH_LATENCY_SUM_EN
  ,
  output logic [TIME_W+CNT_W-1:0] lat_sum_o
`endif
);

  localparam int SUM_W = TIME_W + CNT_W;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, cnt} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0]  probe_q, probe_d, echo_q, echo_d, lost_q, lost_d;
  logic [CNT_W-1:0]  stray_q, stray_d, drop_q, drop_d;
  logic [TIME_W-1:0] min_q, min_d, max_q, max_d;
`ifdef ETH_LATENCY_SUM_EN
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W:0]    sum_ext;
`endif

  always_comb begin
    probe_d = sat_add(probe_q, {1'b0, probe_inc_i});
    echo_d  = sat_add(echo_q, {1'b0, echo_inc_i});
    lost_d  = sat_add(lost_q, lost_inc_i);
    stray_d = sat_add(stray_q, {1'b0, stray_inc_i});
    drop_d  = sat_add(drop_q, {1'b0, drop_inc_i});
    min_d   = (echo_inc_i && lat_i < min_q) ? lat_i : min_q;
    max_d   = (echo_inc_i && lat_i > max_q) ? lat_i : max_q;
`ifdef ETH_LATENCY_SUM_EN
    sum_ext = {1'b0, sum_q} + (SUM_W+1)'(lat_i);
    sum_d   = sum_q;
    if (echo_inc_i) sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`endif
    // Clear wins over anything counted in the same cycle.
    if (stats_clear_i) begin
      probe_d = '0;
      echo_d  = '0;
      lost_d  = '0;
      stray_d = '0;
      drop_d  = '0;
      min_d   = '1;
      max_d   = '0;
`ifdef ETH_LATENCY_SUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_q <= '0;
      echo_q  <= '0;
      lost_q  <= '0;
      stray_q <= '0;
      drop_q  <= '0;
      min_q   <= '1;
      max_q   <= '0;
`ifdef ETH_LATENCY_SUM_EN
      sum_q   <= '0;
`endif
    end else begin
      probe_q <= probe_d;
      echo_q  <= echo_d;
      lost_q  <= lost_d;
      stray_q <= stray_d;
      drop_q  <= drop_d;
      min_q   <= min_d;
      max_q   <= max_d;
`ifdef ETH_LATENCY_SUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign probe_count_o = probe_q;
  assign echo_count_o  = echo_q;
  assign lost_count_o  = lost_q;
  assign stray_count_o = stray_q;
  assign drop_count_o  = drop_q;
  assign lat_min_o     = min_q;
  assign lat_max_o     = max_q;
`ifdef ETH_LATENCY_SUM_EN
  assign lat_sum_o     = sum_q;
`endif

endmodule

`default_nettype wire

// File: rtl/eth_latency_tracker.sv
// ============================================================================
// Module  : eth_latency_tracker
// Brief   : Multi-outstanding probe table, timeout scanner and result register.
//           Optional lat_sum output when ETH_LATENCY_SUM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_latency_tracker
  import eth_latency_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int SEQ_W      = SEQ_W_DEF,
  parameter int TIME_W     = TIME_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [TIME_W-1:0] current_time,
  input  wire logic              time_running,
  input  wire logic [TIME_W-1:0] timeout,
  input  wire logic              stats_clear,
  eth_latency_tracker_if.slave   bus,
  output logic      [CNT_W-1:0]  probe_count,
  output logic      [CNT_W-1:0]  echo_count,
  output logic      [CNT_W-1:0]  lost_count,
  output logic      [CNT_W-1:0]  stray_count,
  output logic      [CNT_W-1:0]  drop_count,
  output logic      [TIME_W-1:0] lat_min,
  output logic      [TIME_W-1:0] lat_max
`ifdef ETH_LATENCY_SUM_EN
  ,
  output logic [TIME_W+CNT_W-1:0] lat_sum
`endif
);

  localparam int SLOTS = 2**DEPTH_LOG2;

  typedef struct packed {
    logic              pending;
    logic [SEQ_W-1:0]  tag;
    logic [TIME_W-1:0] stamp;
  } slot_t;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [TIME_W-1:0] latency;
    logic              timeout;
  } res_t;

  slot_t                 table_q [SLOTS];
  slot_t                 table_d [SLOTS];
  logic [DEPTH_LOG2-1:0] scan_ptr_q, scan_ptr_d;
  res_t                  res_q, res_d;
  logic                  res_valid_q, res_valid_d;

  logic [DEPTH_LOG2-1:0] w_rx_slot, w_tx_slot;
  slot_t                 w_rx_ent, w_scan_ent;
  logic [TIME_W-1:0]     w_rx_lat, w_scan_age;
  logic                  w_rx_act, w_tx_act, w_rx_hit, w_scan_hit, w_can_load;
  logic                  w_rx_load, w_scan_load, w_tx_over;

  always_comb begin
    w_rx_slot   = bus.rx_seq[DEPTH_LOG2-1:0];
    w_tx_slot   = bus.tx_seq[DEPTH_LOG2-1:0];
    w_rx_act    = time_running && bus.rx_valid;
    w_tx_act    = time_running && bus.tx_valid;
    w_rx_ent    = table_q[w_rx_slot];
    w_scan_ent  = table_q[scan_ptr_q];
    w_rx_lat    = current_time - w_rx_ent.stamp;
    w_scan_age  = current_time - w_scan_ent.stamp;
    w_rx_hit    = w_rx_act && w_rx_ent.pending && (w_rx_ent.tag == bus.rx_seq);
    w_scan_hit  = time_running && w_scan_ent.pending && (w_scan_age > timeout) &&
                  !(w_rx_hit && (w_rx_slot == scan_ptr_q));
    w_can_load  = !res_valid_q || bus.res_ready;
    w_rx_load   = w_rx_hit && w_can_load;
    w_scan_load = w_scan_hit && w_can_load && !w_rx_hit;
    // An overwrite only loses a probe if the slot is still pending after this cycle's rx/scan clear.
    w_tx_over   = w_tx_act && table_q[w_tx_slot].pending &&
                  !(w_rx_hit && (w_rx_slot == w_tx_slot)) &&
                  !(w_scan_load && (scan_ptr_q == w_tx_slot));

    for (int i = 0; i < SLOTS; i++) begin
      table_d[i] = table_q[i];
      if ((w_rx_hit && (w_rx_slot == DEPTH_LOG2'(i))) ||
          (w_scan_load && (scan_ptr_q == DEPTH_LOG2'(i))))
        table_d[i].pending = 1'b0;
      if (w_tx_act && (w_tx_slot == DEPTH_LOG2'(i)))
        table_d[i] = '{pending: 1'b1, tag: bus.tx_seq, stamp: current_time};
    end

    scan_ptr_d = scan_ptr_q;
    if (time_running && !(w_scan_hit && !w_scan_load))
      scan_ptr_d = scan_ptr_q + 1'b1;

    res_d       = res_q;
    res_valid_d = res_valid_q && !bus.res_ready;
    if (w_rx_load) begin
      res_d       = '{seq: bus.rx_seq, latency: w_rx_lat, timeout: 1'b0};
      res_valid_d = 1'b1;
    end else if (w_scan_load) begin
      res_d       = '{seq: w_scan_ent.tag, latency: '0, timeout: 1'b1};
      res_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) table_q[i] <= '0;
      scan_ptr_q  <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) table_q[i] <= table_d[i];
      scan_ptr_q  <= scan_ptr_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.res_valid   = res_valid_q;
  assign bus.res_seq     = res_q.seq;
  assign bus.res_latency = res_q.latency;
  assign bus.res_timeout = res_q.timeout;

  eth_latency_stats #(
    .TIME_W (TIME_W),
    .CNT_W  (CNT_W)
  ) u_stats (
    .clk           (clk),
    .rst           (rst),
    .stats_clear_i (stats_clear),
    .probe_inc_i   (w_tx_act),
    .echo_inc_i    (w_rx_hit),
    .lat_i         (w_rx_lat),
    .lost_inc_i    ({1'b0, w_tx_over} + {1'b0, w_scan_load}),
    .stray_inc_i   (w_rx_act && !w_rx_hit),
    .drop_inc_i    (w_rx_hit && !w_can_load),
    .probe_count_o (probe_count),
    .echo_count_o  (echo_count),
    .lost_count_o  (lost_count),
    .stray_count_o (stray_count),
    .drop_count_o  (drop_count),
    .lat_min_o     (lat_min),
    .lat_max_o     (lat_max)
`ifdef ETH_LATENCY_SUM_EN
    ,
    .lat_sum_o     (lat_sum)
`endif
  );

endmodule

`default_nettype wire
